ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Shares one 16x8 RAM between the CPU datapath and a burst loader,
//            handing the RAM to the loader only at instruction boundaries.
// Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
    parameter int BURST_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ctrl_data,
    input  logic [2:0]  cpu_step,
    input  logic [7:0]  bus_in,
    input  logic [7:0]  ram_rdata,
    input  logic        ld_req,
    input  logic        ld_valid,
    input  logic        ld_we,
    input  logic [3:0]  ld_addr,
    input  logic [7:0]  ld_wdata,
    output logic [3:0]  ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    output logic        cpu_hold,
    output logic        ld_gnt,
    output logic        ld_ack,
    output logic [7:0]  ld_rdata
);

    localparam logic [1:0] c_ST_CPU     = 2'd0;
    localparam logic [1:0] c_ST_DRAIN   = 2'd1;
    localparam logic [1:0] c_ST_GRANT   = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    localparam logic [7:0] c_BURST_LAST = BURST_MAX[7:0];

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [3:0] r_mar;
    logic       r_halted;
    logic       r_cooldown;
    logic [7:0] r_cnt;
    logic       r_ld_ack;
    logic [7:0] r_ld_rdata;

    logic       w_hlt;
    logic       w_mi;
    logic       w_ri;
    logic       w_accept;
    logic [7:0] w_cnt_inc;
    logic       w_unused_bits;

    assign w_hlt         = ctrl_data[15];
    assign w_mi          = ctrl_data[14];
    assign w_ri          = ctrl_data[13];
    assign w_unused_bits = ^ctrl_data[12:0];

    assign w_accept  = (r_state == c_ST_GRANT) && ld_req && ld_valid;
    assign w_cnt_inc = r_cnt + 8'd1;

    assign ld_ack   = r_ld_ack;
    assign ld_rdata = r_ld_rdata;

    always_comb begin
        w_state_next = r_state;
        ram_addr     = r_mar;
        ram_wdata    = bus_in;
        ram_we       = w_ri;
        cpu_hold     = 1'b0;
        ld_gnt       = 1'b0;
        case (r_state)
            c_ST_CPU: begin
                // A halted CPU never advances its step, so waiting is pointless
                if (ld_req && (!r_cooldown || r_halted))
                    w_state_next = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                cpu_hold = (cpu_step == 3'd0) || r_halted;
                if (cpu_hold)
                    ram_we = 1'b0;
                if (!ld_req)
                    w_state_next = c_ST_CPU;
                else if (cpu_hold)
                    w_state_next = c_ST_GRANT;
            end
            c_ST_GRANT: begin
                cpu_hold  = 1'b1;
                ld_gnt    = 1'b1;
                ram_addr  = ld_addr;
                ram_wdata = ld_wdata;
                ram_we    = ld_valid & ld_we & ld_req;
                if (!ld_req)
                    w_state_next = c_ST_RELEASE;
                else if (w_accept && (w_cnt_inc == c_BURST_LAST))
                    w_state_next = c_ST_RELEASE;
            end
            default: begin
                cpu_hold     = 1'b1;
                ram_we       = 1'b0;
                w_state_next = c_ST_CPU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_CPU;
            r_mar      <= 4'd0;
            r_halted   <= 1'b0;
            r_cooldown <= 1'b0;
            r_cnt      <= 8'd0;
            r_ld_ack   <= 1'b0;
            r_ld_rdata <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_mi && !cpu_hold)
                r_mar <= bus_in[3:0];
            if (w_hlt && ((r_state == c_ST_CPU) || (r_state == c_ST_DRAIN)))
                r_halted <= 1'b1;
            if (r_state == c_ST_RELEASE)
                r_cooldown <= 1'b1;
            else if (cpu_step != 3'd0)
                r_cooldown <= 1'b0;
            if (r_state != c_ST_GRANT)
                r_cnt <= 8'd0;
            else if (w_accept)
                r_cnt <= w_cnt_inc;
            r_ld_ack <= w_accept;
            // Writes echo their own data so the loader sees one uniform ack
            if (w_accept)
                r_ld_rdata <= ld_we ? ld_wdata : ram_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed self-checking bench for ram_arbiter with a 16x8 RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] ctrl_data;
    logic [2:0]  cpu_step;
    logic [7:0]  bus_in;
    logic [7:0]  ram_rdata;
    logic        ld_req;
    logic        ld_valid;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [7:0]  ld_wdata;
    logic [3:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic        cpu_hold;
    logic        ld_gnt;
    logic        ld_ack;
    logic [7:0]  ld_rdata;

    logic [7:0]  mem [16];
    int          n_checks;
    int          n_pass;

    localparam logic [15:0] c_HLT = 16'h8000;
    localparam logic [15:0] c_MI  = 16'h4000;
    localparam logic [15:0] c_RI  = 16'h2000;

    ram_arbiter #(.BURST_MAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl_data (ctrl_data),
        .cpu_step  (cpu_step),
        .bus_in    (bus_in),
        .ram_rdata (ram_rdata),
        .ld_req    (ld_req),
        .ld_valid  (ld_valid),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .cpu_hold  (cpu_hold),
        .ld_gnt    (ld_gnt),
        .ld_ack    (ld_ack),
        .ld_rdata  (ld_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL reset_hold got %b want 0", cpu_hold); else n_pass++;
        n_checks++; if (ld_gnt !== 1'b0) $display("FAIL reset_gnt got %b want 0", ld_gnt); else n_pass++;
        n_checks++; if (ld_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", ld_ack); else n_pass++;
        n_checks++; if (ld_rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", ld_rdata); else n_pass++;
        n_checks++; if (ram_addr !== 4'd0) $display("FAIL reset_mar got %0d want 0", ram_addr); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_we_idle got %b want 0", ram_we); else n_pass++;
        ctrl_data = c_RI;
        #1;
        n_checks++; if (ram_we !== 1'b1) $display("FAIL reset_we_ri got %b want 1", ram_we); else n_pass++;
        ctrl_data = 16'h0000;
    endtask

    task automatic test_passthrough();
        ctrl_data = c_MI;
        bus_in    = 8'h07;
        tick();
        ctrl_data = c_RI;
        bus_in    = 8'h5A;
        #1;
        n_checks++; if (ram_addr !== 4'd7) $display("FAIL pt_addr got %0d want 7", ram_addr); else n_pass++;
        n_checks++; if (ram_we !== 1'b1) $display("FAIL pt_we got %b want 1", ram_we); else n_pass++;
        n_checks++; if (ram_wdata !== 8'h5A) $display("FAIL pt_wdata got %h want 5a", ram_wdata); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL pt_hold got %b want 0", cpu_hold); else n_pass++;
        tick();
        ctrl_data = 16'h0000;
        n_checks++; if (mem[7] !== 8'h5A) $display("FAIL pt_mem got %h want 5a", mem[7]); else n_pass++;
    endtask

    task automatic test_drain();
        cpu_step = 3'd2;
        ld_req   = 1'b1;
        #1;
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL drain_s2_hold got %b want 0", cpu_hold); else n_pass++;
        tick();
        cpu_step = 3'd3;
        #1;
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL drain_s3_hold got %b want 0", cpu_hold); else n_pass++;
        tick();
        cpu_step = 3'd4;
        #1;
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL drain_s4_hold got %b want 0", cpu_hold); else n_pass++;
        tick();
        cpu_step  = 3'd0;
        ctrl_data = c_MI | c_RI;
        bus_in    = 8'h0F;
        #1;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL drain_s0_hold got %b want 1", cpu_hold); else n_pass++;
        n_checks++; if (ld_gnt !== 1'b0) $display("FAIL drain_s0_gnt got %b want 0", ld_gnt); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL drain_we_forced got %b want 0", ram_we); else n_pass++;
        tick();
        ctrl_data = 16'h0000;
        #1;
        n_checks++; if (ld_gnt !== 1'b1) $display("FAIL drain_gnt got %b want 1", ld_gnt); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL drain_grant_hold got %b want 1", cpu_hold); else n_pass++;
    endtask

    task automatic test_loader_rw();
        ld_valid = 1'b1;
        ld_we    = 1'b1;
        ld_addr  = 4'd3;
        ld_wdata = 8'hC3;
        #1;
        n_checks++; if (ram_we !== 1'b1) $display("FAIL ldw_we got %b want 1", ram_we); else n_pass++;
        n_checks++; if (ram_addr !== 4'd3) $display("FAIL ldw_addr got %0d want 3", ram_addr); else n_pass++;
        n_checks++; if (ram_wdata !== 8'hC3) $display("FAIL ldw_wdata got %h want c3", ram_wdata); else n_pass++;
        tick();
        ld_we    = 1'b0;
        ld_wdata = 8'h00;
        #1;
        n_checks++; if (ld_ack !== 1'b1) $display("FAIL ldw_ack got %b want 1", ld_ack); else n_pass++;
        n_checks++; if (ld_rdata !== 8'hC3) $display("FAIL ldw_echo got %h want c3", ld_rdata); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL ldr_we got %b want 0", ram_we); else n_pass++;
        tick();
        ld_valid = 1'b0;
        #1;
        n_checks++; if (ld_ack !== 1'b1) $display("FAIL ldr_ack got %b want 1", ld_ack); else n_pass++;
        n_checks++; if (ld_rdata !== 8'hC3) $display("FAIL ldr_rdata got %h want c3", ld_rdata); else n_pass++;
        tick();
        n_checks++; if (ld_ack !== 1'b0) $display("FAIL ld_ack_pulse got %b want 0", ld_ack); else n_pass++;
        // valid without request must be ignored
        ld_req   = 1'b0;
        ld_valid = 1'b1;
        ld_we    = 1'b1;
        ld_addr  = 4'd5;
        ld_wdata = 8'hEE;
        #1;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL noreq_we got %b want 0", ram_we); else n_pass++;
        tick();
        n_checks++; if (ld_ack !== 1'b0) $display("FAIL noreq_ack got %b want 0", ld_ack); else n_pass++;
        n_checks++; if (ld_gnt !== 1'b0) $display("FAIL release_gnt got %b want 0", ld_gnt); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL release_hold got %b want 1", cpu_hold); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL release_we got %b want 0", ram_we); else n_pass++;
        tick();
        ld_valid = 1'b0;
        #1;
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL resume_hold got %b want 0", cpu_hold); else n_pass++;
        n_checks++; if (ram_addr !== 4'd7) $display("FAIL resume_mar got %0d want 7", ram_addr); else n_pass++;
        n_checks++; if (mem[5] !== 8'h00) $display("FAIL noreq_mem got %h want 00", mem[5]); else n_pass++;
    endtask

    task automatic test_burst();
        // CPU left RELEASE with cooldown set and step still 0
        ld_req = 1'b1;
        tick();
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL cool_hold got %b want 0", cpu_hold); else n_pass++;
        cpu_step = 3'd1;
        tick();
        tick();
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL cool_drain_hold got %b want 0", cpu_hold); else n_pass++;
        cpu_step = 3'd0;
        #1;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL cool_drain_s0 got %b want 1", cpu_hold); else n_pass++;
        tick();
        n_checks++; if (ld_gnt !== 1'b1) $display("FAIL burst_gnt got %b want 1", ld_gnt); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1;
            ld_we    = 1'b1;
            ld_addr  = 4'(i);
            ld_wdata = 8'h10 + 8'(i);
            tick();
            if (i == 14) begin
                n_checks++; if (ld_gnt !== 1'b1) $display("FAIL burst_gnt15 got %b want 1", ld_gnt); else n_pass++;
            end
        end
        ld_valid = 1'b0;
        #1;
        n_checks++; if (ld_gnt !== 1'b0) $display("FAIL burst_release_gnt got %b want 0", ld_gnt); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL burst_release_hold got %b want 1", cpu_hold); else n_pass++;
        n_checks++; if (ld_ack !== 1'b1) $display("FAIL burst_ack16 got %b want 1", ld_ack); else n_pass++;
        n_checks++; if (ld_rdata !== 8'h1F) $display("FAIL burst_rdata16 got %h want 1f", ld_rdata); else n_pass++;
        n_checks++; if (mem[9] !== 8'h19) $display("FAIL burst_mem9 got %h want 19", mem[9]); else n_pass++;
        tick();
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL burst_cpu_hold got %b want 0", cpu_hold); else n_pass++;
        tick();
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL burst_wait_hold got %b want 0", cpu_hold); else n_pass++;
        n_checks++; if (ld_gnt !== 1'b0) $display("FAIL burst_wait_gnt got %b want 0", ld_gnt); else n_pass++;
        cpu_step = 3'd1;
        tick();
        tick();
        cpu_step = 3'd0;
        tick();
        n_checks++; if (ld_gnt !== 1'b1) $display("FAIL regrant_gnt got %b want 1", ld_gnt); else n_pass++;
        ld_req = 1'b0;
        tick();
        tick();
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL regrant_done_hold got %b want 0", cpu_hold); else n_pass++;
    endtask

    task automatic test_halt();
        // cooldown is still set here (step 0), so the grant below proves the bypass
        ctrl_data = c_HLT;
        tick();
        ctrl_data = 16'h0000;
        ld_req    = 1'b1;
        tick();
        cpu_step  = 3'd3;
        ctrl_data = c_RI;
        #1;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL halt_hold got %b want 1", cpu_hold); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL halt_we got %b want 0", ram_we); else n_pass++;
        tick();
        ctrl_data = 16'h0000;
        #1;
        n_checks++; if (ld_gnt !== 1'b1) $display("FAIL halt_gnt got %b want 1", ld_gnt); else n_pass++;
    endtask

    task automatic test_reset_mid_grant();
        ld_valid = 1'b1;
        ld_we    = 1'b1;
        ld_addr  = 4'd2;
        ld_wdata = 8'hAB;
        ld_req   = 1'b0;
        rst      = 1'b1;
        #1;
        n_checks++; if (ld_gnt !== 1'b1) $display("FAIL rstg_pre_gnt got %b want 1", ld_gnt); else n_pass++;
        ld_req = 1'b1;
        tick();
        rst      = 1'b0;
        ld_req   = 1'b0;
        ld_valid = 1'b0;
        #1;
        n_checks++; if (ld_gnt !== 1'b0) $display("FAIL rstg_gnt got %b want 0", ld_gnt); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL rstg_hold got %b want 0", cpu_hold); else n_pass++;
        n_checks++; if (ld_ack !== 1'b0) $display("FAIL rstg_ack got %b want 0", ld_ack); else n_pass++;
        n_checks++; if (ram_addr !== 4'd0) $display("FAIL rstg_mar got %0d want 0", ram_addr); else n_pass++;
        n_checks++; if (ld_rdata !== 8'h00) $display("FAIL rstg_rdata got %h want 00", ld_rdata); else n_pass++;
        // halted cleared: a request at a non-zero step must not freeze the CPU
        cpu_step = 3'd3;
        ld_req   = 1'b1;
        tick();
        n_checks++; if (cpu_hold !== 1'b0) $display("FAIL rstg_halt_clr got %b want 0", cpu_hold); else n_pass++;
        ld_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        ctrl_data = 16'h0000;
        cpu_step  = 3'd0;
        bus_in    = 8'h00;
        ld_req    = 1'b0;
        ld_valid  = 1'b0;
        ld_we     = 1'b0;
        ld_addr   = 4'd0;
        ld_wdata  = 8'h00;
        test_reset();
        test_passthrough();
        test_drain();
        test_loader_rw();
        test_burst();
        test_halt();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
